// File: rtl/instruction_stream_memory.sv
// Instruction store loaded word-by-word from the shared tri-state bus, then
// streamed back onto it from an internal program counter (wrap, jump, end-stop).
module instruction_stream_memory #(
    parameter int WIDTH  = 262,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    inout  wire  [WIDTH-1:0]  bus,
    input  logic              in,
    input  logic              out,
    input  logic              enable,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              wrap_en,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W:0]   count,
    output logic              valid,
    output logic              full,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    localparam logic [ADDR_W:0]   CNT_ONE = 1;
    localparam logic [ADDR_W-1:0] PC_ONE  = 1;
    localparam logic [ADDR_W:0]   CNT_MAX = (ADDR_W+1)'(DEPTH);

    state_t            state, state_n;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTH-1:0]  data_q;
    logic              last, last_n;
    logic [ADDR_W-1:0] pc_n, pc_adv;
    logic [ADDR_W:0]   count_n;
    logic              valid_n, err_n, wr, fetch;
    logic              req_ld, req_st, req_jp, conflict, jp_ok, at_end;

    assign req_ld   = enable & in & ~out;
    assign req_st   = enable & out & ~in;
    assign req_jp   = enable & jump & ~in;
    assign conflict = enable & in & out;
    assign jp_ok    = {1'b0, jump_addr} < count;
    assign at_end   = ({1'b0, pc} + CNT_ONE) == count;
    // Without wrap the pc parks on the final word; last marks it as already presented.
    assign pc_adv   = at_end ? (wrap_en ? '0 : pc) : pc + PC_ONE;

    assign full = (count == CNT_MAX);
    assign done = (state == DONE);
    assign bus  = (enable & out & ~in & valid) ? data_q : {WIDTH{1'bz}};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            pc    <= '0;
            count <= '0;
            valid <= 1'b0;
            last  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            count <= count_n;
            valid <= valid_n;
            last  <= last_n;
            err   <= err_n;
        end
    end

    // Storage is deliberately not reset; count decides which entries are live.
    always_ff @(posedge clock) begin
        if (wr)    mem[count[ADDR_W-1:0]] <= bus;
        if (fetch) data_q <= mem[pc];
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        count_n = count;
        valid_n = valid;
        last_n  = last;
        err_n   = err;
        wr      = 1'b0;
        fetch   = 1'b0;
        if (conflict) err_n = 1'b1;
        if (req_ld) begin
            if (full) begin
                err_n = 1'b1;
            end else begin
                wr      = 1'b1;
                count_n = count + CNT_ONE;
            end
        end
        if (req_jp && !jp_ok) err_n = 1'b1;
        if (req_jp && jp_ok) begin
            pc_n    = jump_addr;
            valid_n = 1'b0;
            last_n  = 1'b0;
            state_n = IDLE;
        end else if (!conflict) begin
            case (state)
                IDLE: begin
                    if (req_st && count != '0) begin
                        fetch   = 1'b1;
                        valid_n = 1'b1;
                        pc_n    = pc_adv;
                        last_n  = at_end & ~wrap_en;
                        state_n = STREAM;
                    end
                end
                STREAM: begin
                    if (!req_st) begin
                        valid_n = 1'b0;
                        last_n  = 1'b0;
                        state_n = IDLE;
                    end else if (last) begin
                        valid_n = 1'b0;
                        last_n  = 1'b0;
                        state_n = DONE;
                    end else begin
                        fetch  = 1'b1;
                        pc_n   = pc_adv;
                        last_n = at_end & ~wrap_en;
                    end
                end
                DONE:    ;
                default: state_n = IDLE;
            endcase
        end
    end
endmodule
